fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, meaning PC loaded on reset.
REQ-002 Parameter ALIGN_CHECK, default 1, meaning 1 = trap redirect targets with addr[1:0]!=0.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-005 redirect_valid  input  1  branch/jump taken this cycle (pc_sel equivalent).
REQ-006 redirect_pc  input  32  redirect target from ALU.
REQ-007 stall  input  1  hold fetch; no new request issued while high.
REQ-008 imem_req_valid  output  1  instruction memory request valid.
REQ-009 imem_req_addr  output  32  request address.
REQ-010 imem_req_ready  input  1  memory accepts request.
REQ-011 imem_rsp_valid  input  1  response data valid (one-cycle pulse).
REQ-012 imem_rsp_data  input  32  fetched instruction word.
REQ-013 inst_valid  output  1  instruction available to decode.
REQ-014 inst_data  output  32  instruction word.
REQ-015 inst_pc  output  32  address of inst_data.
REQ-016 inst_ready  input  1  decode consumes instruction.
REQ-017 misalign_err  output  1  one-cycle pulse, misaligned redirect target.
REQ-018 pc  output  32  current fetch PC.

Function
REQ-019 States: REQ, WAIT, HOLD, TRAP; at most one outstanding memory request.
REQ-020 REQ: imem_req_valid = !stall, imem_req_addr = pc; on valid&&ready -> WAIT.
REQ-021 WAIT: on imem_rsp_valid with no pending flush, capture data/pc into output register, pc <= pc+4 (mod 2^32, wrap 0xFFFFFFFC -> 0x0), -> HOLD.
REQ-022 HOLD: inst_valid=1, outputs stable until inst_ready; on inst_ready -> REQ (request issue in that REQ cycle, so sustained throughput 1 instr per 3 cycles minimum with zero-latency memory).
REQ-023 Redirect (aligned) in REQ or HOLD: pc <= redirect_pc next cycle, inst_valid dropped, -> REQ; a redirect coincident with req handshake cancels that handshake's effect by setting flush.
REQ-024 Redirect in WAIT: pc <= redirect_pc, flush flag set; matching response is discarded, flush cleared, -> REQ.
REQ-025 Redirect has priority over stall, inst_ready and response capture in the same cycle.
REQ-026 ALIGN_CHECK=1 and redirect_pc[1:0]!=0: misalign_err pulses next cycle, pc <= redirect_pc, -> TRAP (outstanding response still discarded).
REQ-027 TRAP: no requests, inst_valid=0; leave only on aligned redirect -> REQ; misaligned redirect in TRAP re-pulses misalign_err.
REQ-028 stall never affects HOLD output or WAIT response capture.
REQ-029 imem_req_valid, once asserted, stays asserted with stable addr until ready unless redirect or stall rises.

Reset
REQ-030 While reset=0 at clk edge: state=REQ, pc=RESET_PC, flush=0, inst_valid=0, inst_data=0, inst_pc=0, misalign_err=0, imem_req_valid=0 during reset cycle.
REQ-031 Reset mid-WAIT: in-flight response after reset release is discarded (flush=1 out of reset if previous state was WAIT).

Structure
REQ-032 Shared package holds state enum, XLEN=32, INSTR_BYTES=4.
REQ-033 Existing pc register block reused as submodule for pc storage; FSM and output register in fetch_sequencer.

Verification
REQ-034 Reset low 2 cycles, release, memory ready/1-cycle rsp -> inst_pc 0x0, 0x4, 0x8, 0xC in order.
REQ-035 Redirect 0x1000 during WAIT -> old response dropped, next inst_pc 0x1000 then 0x1004.
REQ-036 Redirect 0x203 -> misalign_err one cycle, no requests; redirect 0x2000 -> fetch resumes at 0x2000.
REQ-037 inst_ready held low 5 cycles in HOLD -> inst_data/inst_pc stable, no new request.
REQ-038 stall high in REQ -> imem_req_valid=0; stall+redirect 0x100 same cycle -> pc=0x100.
REQ-039 RESET_PC=0xFFFFFFFC -> second fetch address 0x00000000.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pkg
// Shared definitions for the instruction fetch sequencer:
//   XLEN          - architectural address/data width
//   INSTR_BYTES   - bytes per instruction (sequential PC step)
//   fetch_state_e - sequencer FSM states
//   next_pc()     - sequential successor of a PC (wraps modulo 2^XLEN)
//   addr_misaligned() - true when an address is not instruction aligned
// -----------------------------------------------------------------------------
package fetch_sequencer_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        ST_REQ  = 2'b00,  // issue a request at pc
        ST_WAIT = 2'b01,  // one request outstanding, waiting for its response
        ST_HOLD = 2'b10,  // instruction presented to decode
        ST_TRAP = 2'b11   // misaligned redirect seen, fetch parked
    } fetch_state_e;

    // Sequential successor; natural overflow gives the 0xFFFFFFFC -> 0x0 wrap.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] cur);
        return cur + XLEN'(INSTR_BYTES);
    endfunction

    function automatic logic addr_misaligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
// Bundles the instruction-memory request/response channel and the
// decode-facing instruction channel of the fetch sequencer.
//   master : the fetch sequencer (drives requests and instructions)
//   slave  : memory + decode side (drives ready, responses, inst_ready)
// -----------------------------------------------------------------------------
interface fetch_sequencer_if;
    import fetch_sequencer_pkg::*;

    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            inst_valid;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output inst_valid,
        output inst_data,
        output inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  inst_valid,
        input  inst_data,
        input  inst_pc,
        output inst_ready
    );

endinterface

// File: rtl/fetch_sequencer_pc.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pc
// Program counter storage block.
// Ports:
//   clk      - clock, state updates on rising edge
//   reset    - synchronous active-low reset, loads RESET_PC
//   load_en  - load load_pc (redirect); has priority over inc_en
//   load_pc  - redirect target
//   inc_en   - advance to the next sequential instruction
//   pc       - current PC (registered)
// -----------------------------------------------------------------------------
module fetch_sequencer_pc
    import fetch_sequencer_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_en,
    input  logic [XLEN-1:0] load_pc,
    input  logic            inc_en,
    output logic [XLEN-1:0] pc
);

    logic [XLEN-1:0] pc_r;

    // PC register: reset value, redirect load, or sequential advance
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_r <= RESET_PC;
        end else if (load_en) begin
            pc_r <= load_pc;
        end else if (inc_en) begin
            pc_r <= next_pc(pc_r);
        end else begin
            pc_r <= pc_r;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Single-outstanding instruction fetch sequencer. Issues a request at pc,
// waits for the response, presents the instruction to decode until it is
// consumed, then advances. Redirects reload pc; a response belonging to a
// request made before the redirect is dropped via the flush flag.
// Misaligned redirect targets (ALIGN_CHECK=1) park the sequencer in TRAP
// and pulse misalign_err until an aligned redirect arrives.
// Ports:
//   clk            - clock, rising edge
//   reset          - synchronous active-low reset
//   redirect_valid - branch/jump taken this cycle
//   redirect_pc    - redirect target
//   stall          - suppresses new request issue
//   bus            - memory request/response and decode instruction channel
//   misalign_err   - one-cycle pulse for a misaligned redirect target
//   pc             - current fetch PC
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
    parameter bit              ALIGN_CHECK = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 redirect_valid,
    input  logic [XLEN-1:0]      redirect_pc,
    input  logic                 stall,
    fetch_sequencer_if.master    bus,
    output logic                 misalign_err,
    output logic [XLEN-1:0]      pc
);

    fetch_state_e    state_r;
    logic            flush_r;
    logic            inst_valid_r;
    logic [XLEN-1:0] inst_data_r;
    logic [XLEN-1:0] inst_pc_r;
    logic            misalign_err_r;

    logic [XLEN-1:0] pc_s;
    logic            req_valid_s;
    logic            handshake_s;
    logic            pending_s;
    logic            misaligned_s;
    logic            capture_s;
    logic            pc_load_s;
    logic            pc_inc_s;

    fetch_sequencer_pc #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk     (clk),
        .reset   (reset),
        .load_en (pc_load_s),
        .load_pc (redirect_pc),
        .inc_en  (pc_inc_s),
        .pc      (pc_s)
    );

    // Request issue, handshake detection and pc update decode
    always_comb begin
        req_valid_s  = 1'b0;
        handshake_s  = 1'b0;
        pending_s    = 1'b0;
        misaligned_s = 1'b0;
        capture_s    = 1'b0;
        pc_load_s    = 1'b0;
        pc_inc_s     = 1'b0;

        // A set flush_r in REQ means a stale response is still in flight;
        // holding off issue keeps at most one request outstanding.
        if (reset && (state_r == ST_REQ) && !flush_r && !stall) begin
            req_valid_s = 1'b1;
        end else begin
            req_valid_s = 1'b0;
        end

        handshake_s = req_valid_s && bus.imem_req_ready;

        // A response is still owed to us either in WAIT or while flushing.
        pending_s = (state_r == ST_WAIT) || flush_r;

        if (ALIGN_CHECK) begin
            misaligned_s = addr_misaligned(redirect_pc);
        end else begin
            misaligned_s = 1'b0;
        end

        if (!redirect_valid && (state_r == ST_WAIT) && bus.imem_rsp_valid && !flush_r) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end

        pc_load_s = redirect_valid;
        pc_inc_s  = capture_s;
    end

    // Sequencing FSM together with the decode-facing output register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r        <= ST_REQ;
            // A request accepted before reset still returns afterwards; mark
            // it stale unless it is arriving right now.
            flush_r        <= (state_r == ST_WAIT) && !bus.imem_rsp_valid;
            inst_valid_r   <= 1'b0;
            inst_data_r    <= {XLEN{1'b0}};
            inst_pc_r      <= {XLEN{1'b0}};
            misalign_err_r <= 1'b0;
        end else if (redirect_valid) begin
            // Redirect wins over stall, inst_ready and response capture.
            misalign_err_r <= misaligned_s;
            inst_valid_r   <= 1'b0;
            flush_r        <= (pending_s && !bus.imem_rsp_valid) || handshake_s;
            if (misaligned_s) begin
                state_r <= ST_TRAP;
            end else begin
                state_r <= ST_REQ;
            end
        end else begin
            misalign_err_r <= 1'b0;
            case (state_r)
                ST_REQ: begin
                    if (flush_r) begin
                        if (bus.imem_rsp_valid) begin
                            flush_r <= 1'b0;
                        end
                    end else if (handshake_s) begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (capture_s) begin
                        inst_valid_r <= 1'b1;
                        inst_data_r  <= bus.imem_rsp_data;
                        inst_pc_r    <= pc_s;
                        state_r      <= ST_HOLD;
                    end else if (bus.imem_rsp_valid) begin
                        flush_r <= 1'b0;
                        state_r <= ST_REQ;
                    end
                end
                ST_HOLD: begin
                    if (bus.inst_ready) begin
                        inst_valid_r <= 1'b0;
                        state_r      <= ST_REQ;
                    end
                end
                ST_TRAP: begin
                    if (flush_r && bus.imem_rsp_valid) begin
                        flush_r <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= ST_REQ;
                    flush_r      <= 1'b0;
                    inst_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req_valid = req_valid_s;
    assign bus.imem_req_addr  = pc_s;
    assign bus.inst_valid     = inst_valid_r;
    assign bus.inst_data      = inst_data_r;
    assign bus.inst_pc        = inst_pc_r;
    assign misalign_err       = misalign_err_r;
    assign pc                 = pc_s;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed scenarios followed by randomized traffic. A transaction-level
// reference model tracks the expected PC, whether a response is owed and
// whether it is stale, the presented instruction and the trap condition.
// A second instance with RESET_PC=0xFFFFFFFC checks sequential wrap.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    localparam logic [31:0] MAIN_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] WRAP_RESET_PC = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        misalign_err;
    logic [31:0] pc;
    logic        misalign_err_w;
    logic [31:0] pc_w;

    fetch_sequencer_if bus();
    fetch_sequencer_if bus_w();

    fetch_sequencer #(.RESET_PC(MAIN_RESET_PC), .ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .stall(stall), .bus(bus),
        .misalign_err(misalign_err), .pc(pc)
    );

    fetch_sequencer #(.RESET_PC(WRAP_RESET_PC), .ALIGN_CHECK(1'b1)) dut_w (
        .clk(clk), .reset(reset), .redirect_valid(1'b0),
        .redirect_pc(32'h0000_0000), .stall(1'b0), .bus(bus_w),
        .misalign_err(misalign_err_w), .pc(pc_w)
    );

    // Wrap instance: always-ready memory answering one cycle after accept
    assign bus_w.imem_req_ready = 1'b1;
    assign bus_w.inst_ready     = 1'b1;
    assign bus_w.imem_rsp_data  = 32'h0000_0013;
    always_ff @(posedge clk) begin
        if (!reset) bus_w.imem_rsp_valid <= 1'b0;
        else        bus_w.imem_rsp_valid <= bus_w.imem_req_valid && bus_w.imem_req_ready;
    end
    logic [31:0] wq[$];
    always @(posedge clk) begin
        if (reset && bus_w.imem_req_valid && bus_w.imem_req_ready) wq.push_back(bus_w.imem_req_addr);
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // reference model
    logic [31:0] m_pc, m_ipc, m_idata;
    logic        m_out, m_disc, m_have, m_trap, m_err;

    // memory model (one outstanding)
    bit          mem_busy = 1'b0;
    int          mem_lat  = 0;
    logic [31:0] mem_addr = 32'h0;
    int          lat_fix  = 0;

    logic [31:0] deliv[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3C3_A5A5;
    endfunction

    function automatic logic [31:0] deliv_at(input int i);
        if (deliv.size() > i) return deliv[i];
        else return 32'hDEAD_BEEF;
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: drive memory response, compare, advance model and memory.
    task automatic cycle();
        logic        rsp, exp_rv, hs, misal;
        logic [31:0] n_pc, n_ipc, n_idata;
        logic        n_out, n_disc, n_have, n_trap, n_err;
        rsp = mem_busy && (mem_lat == 0);
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? mem_word(mem_addr) : $urandom();
        #1;
        exp_rv = reset && !m_trap && !m_have && !m_out && !stall;
        check32("imem_req_valid", {31'b0, bus.imem_req_valid}, {31'b0, exp_rv});
        if (exp_rv) check32("imem_req_addr", bus.imem_req_addr, m_pc);
        check32("inst_valid", {31'b0, bus.inst_valid}, {31'b0, m_have});
        check32("inst_data", bus.inst_data, m_idata);
        check32("inst_pc", bus.inst_pc, m_ipc);
        check32("misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
        check32("pc", pc, m_pc);
        if (bus.inst_valid && bus.inst_ready) deliv.push_back(bus.inst_pc);

        hs    = exp_rv && bus.imem_req_ready;
        misal = (redirect_pc[1:0] != 2'b00);
        n_pc = m_pc; n_ipc = m_ipc; n_idata = m_idata;
        n_out = m_out; n_disc = m_disc; n_have = m_have; n_trap = m_trap; n_err = 1'b0;
        if (!reset) begin
            n_pc = MAIN_RESET_PC; n_have = 1'b0; n_ipc = 32'h0; n_idata = 32'h0; n_trap = 1'b0;
            n_out = m_out && !m_disc && !rsp;
            n_disc = n_out;
        end else if (redirect_valid) begin
            n_pc = redirect_pc; n_have = 1'b0; n_trap = misal; n_err = misal;
            if (m_out) begin
                n_out = !rsp; n_disc = 1'b1;
            end else if (hs) begin
                n_out = 1'b1; n_disc = 1'b1;
            end
        end else if (m_trap) begin
            if (m_out && rsp) n_out = 1'b0;
        end else if (m_have) begin
            if (bus.inst_ready) n_have = 1'b0;
        end else if (m_out) begin
            if (rsp) begin
                n_out = 1'b0;
                if (!m_disc) begin
                    n_have = 1'b1; n_ipc = m_pc; n_idata = mem_word(mem_addr); n_pc = m_pc + 32'd4;
                end
            end
        end else if (hs) begin
            n_out = 1'b1; n_disc = 1'b0;
        end

        if (rsp) mem_busy = 1'b0;
        else if (mem_busy) mem_lat--;
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            mem_busy = 1'b1;
            mem_addr = bus.imem_req_addr;
            mem_lat  = (lat_fix < 0) ? int'($urandom_range(0, 2)) : lat_fix;
        end

        @(posedge clk);
        #1;
        cyc++;
        m_pc = n_pc; m_ipc = n_ipc; m_idata = n_idata;
        m_out = n_out; m_disc = n_disc; m_have = n_have; m_trap = n_trap; m_err = n_err;
    endtask

    task automatic drain_then_issue(input string tag);
        for (int i = 0; i < 30 && mem_busy; i++) cycle();
        for (int i = 0; i < 30 && !mem_busy; i++) cycle();
        check32(tag, {31'b0, mem_busy}, 32'd1);
    endtask

    task automatic run_until_deliv(input int n);
        for (int i = 0; i < 80 && deliv.size() < n; i++) cycle();
    endtask

    logic [31:0] hd, hp, rp;

    initial begin
        reset = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
        bus.imem_req_ready = 1'b0; bus.inst_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0;
        @(posedge clk);
        #1;
        m_pc = MAIN_RESET_PC; m_ipc = 32'h0; m_idata = 32'h0;
        m_out = 1'b0; m_disc = 1'b0; m_have = 1'b0; m_trap = 1'b0; m_err = 1'b0;
        cycle();                       // second reset cycle, checks reset state
        reset = 1'b1;

        // sequential fetch with zero-latency memory
        bus.imem_req_ready = 1'b1; bus.inst_ready = 1'b1; lat_fix = 0;
        run_until_deliv(4);
        check32("seq0", deliv_at(0), 32'h0000_0000);
        check32("seq1", deliv_at(1), 32'h0000_0004);
        check32("seq2", deliv_at(2), 32'h0000_0008);
        check32("seq3", deliv_at(3), 32'h0000_000C);

        // redirect while a response is outstanding
        lat_fix = 2;
        drain_then_issue("reach_wait_redirect");
        deliv.delete();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_1000;
        cycle();
        redirect_valid = 1'b0;
        run_until_deliv(2);
        check32("redir0", deliv_at(0), 32'h0000_1000);
        check32("redir1", deliv_at(1), 32'h0000_1004);

        // misaligned redirect traps, aligned redirect resumes
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
        cycle();
        redirect_valid = 1'b0;
        check32("misalign_pulse", {31'b0, misalign_err}, 32'd1);
        check32("misalign_pc", pc, 32'h0000_0203);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check32("trap_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
        end
        deliv.delete();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
        cycle();
        redirect_valid = 1'b0;
        run_until_deliv(1);
        check32("resume", deliv_at(0), 32'h0000_2000);

        // decode back-pressure in HOLD
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 40 && !bus.inst_valid; i++) cycle();
        check32("reach_hold", {31'b0, bus.inst_valid}, 32'd1);
        hd = bus.inst_data; hp = bus.inst_pc;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check32("hold_data", bus.inst_data, hd);
            check32("hold_pc", bus.inst_pc, hp);
            check32("hold_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
        end
        bus.inst_ready = 1'b1;
        cycle();

        // stall in REQ, then stall together with a redirect
        stall = 1'b1;
        #1;
        check32("stall_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
        cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        cycle();
        redirect_valid = 1'b0; stall = 1'b0;
        check32("stall_redirect_pc", pc, 32'h0000_0100);

        // reset while a response is outstanding
        drain_then_issue("reach_wait_reset");
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        deliv.delete();
        run_until_deliv(1);
        check32("reset_mid_wait", deliv_at(0), MAIN_RESET_PC);

        // randomized traffic
        lat_fix = -1;
        for (int i = 0; i < 600; i++) begin
            stall              = ($urandom_range(0, 3) == 0);
            bus.imem_req_ready = ($urandom_range(0, 9) < 7);
            bus.inst_ready     = ($urandom_range(0, 9) < 6);
            redirect_valid     = ($urandom_range(0, 11) == 0);
            rp = $urandom() & 32'h0003_FFFF;
            if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) rp = 32'hFFFF_FFFC;
            redirect_pc = rp;
            cycle();
        end
        redirect_valid = 1'b0;

        // wrap instance
        check32("wrap_count", {31'b0, (wq.size() >= 2)}, 32'd1);
        check32("wrap_first", (wq.size() > 0) ? wq[0] : 32'hDEAD_BEEF, WRAP_RESET_PC);
        check32("wrap_second", (wq.size() > 1) ? wq[1] : 32'hDEAD_BEEF, 32'h0000_0000);
        check32("wrap_no_err", {31'b0, misalign_err_w}, 32'd0);
        check32("wrap_pc_aligned", {30'b0, pc_w[1:0]}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
